// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: data-hazard detection from
// Tuse/Tnew, mult/div busy sequencing and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_D,
  input  logic [31:0] Instr_E,
  input  logic [31:0] Instr_M,
  output logic        En_PC,
  output logic        En_IF_ID,
  output logic        Clr_ID_EX,
  output logic        MD_Start,
  output logic        MD_Busy,
  output logic [31:0] Stall_Cnt
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JR,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } op_t;

  // NOTE: every function assigns its result first, so no path leaves it undriven
  // and the combinational logic built from it cannot infer a latch.
  function automatic op_t decode(input logic [31:0] instr);
    decode = OP_NOP;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h20: decode = OP_ADD;
          6'h22: decode = OP_SUB;
          6'h08: decode = OP_JR;
          6'h18: decode = OP_MULT;
          6'h19: decode = OP_MULTU;
          6'h1A: decode = OP_DIV;
          6'h1B: decode = OP_DIVU;
          6'h10: decode = OP_MFHI;
          6'h12: decode = OP_MFLO;
          6'h11: decode = OP_MTHI;
          6'h13: decode = OP_MTLO;
          default: decode = OP_NOP;
        endcase
      end
      6'h0D:   decode = OP_ORI;
      6'h0F:   decode = OP_LUI;
      6'h23:   decode = OP_LW;
      6'h2B:   decode = OP_SW;
      6'h04:   decode = OP_BEQ;
      6'h03:   decode = OP_JAL;
      default: decode = OP_NOP;
    endcase
  endfunction

  function automatic logic [4:0] dest_of(input op_t op, input logic [31:0] instr);
    dest_of = 5'd0;
    case (op)
      OP_ADD, OP_SUB, OP_MFHI, OP_MFLO: dest_of = instr[15:11];
      OP_ORI, OP_LUI, OP_LW:            dest_of = instr[20:16];
      OP_JAL:                           dest_of = 5'd31;
      default:                          dest_of = 5'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_e_of(input op_t op);
    tnew_e_of = 2'd0;
    case (op)
      OP_LW:                                             tnew_e_of = 2'd2;
      OP_ADD, OP_SUB, OP_ORI, OP_LUI, OP_MFHI, OP_MFLO:  tnew_e_of = 2'd1;
      default:                                           tnew_e_of = 2'd0;
    endcase
  endfunction

  function automatic logic is_md_issue(input op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_md_any(input op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
  endfunction

  // Source usage in D: {used, tuse}.
  function automatic logic [2:0] rs_use_of(input op_t op);
    rs_use_of = 3'b0_00;
    case (op)
      OP_BEQ, OP_JR: rs_use_of = 3'b1_00;
      OP_ADD, OP_SUB, OP_ORI, OP_LW, OP_SW, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MTHI, OP_MTLO: rs_use_of = 3'b1_01;
      default: rs_use_of = 3'b0_00;
    endcase
  endfunction

  function automatic logic [2:0] rt_use_of(input op_t op);
    rt_use_of = 3'b0_00;
    case (op)
      OP_BEQ:                                                  rt_use_of = 3'b1_00;
      OP_ADD, OP_SUB, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:      rt_use_of = 3'b1_01;
      OP_SW:                                                   rt_use_of = 3'b1_10;
      default:                                                 rt_use_of = 3'b0_00;
    endcase
  endfunction

  function automatic logic src_hit(input logic [2:0] use_t, input logic [4:0] src,
                                   input logic [4:0] dst, input logic [1:0] tnew);
    return use_t[2] && (dst != 5'd0) && (src == dst) && (use_t[1:0] < tnew);
  endfunction

  op_t              op_d, op_e, op_m;
  logic [4:0]       dst_e, dst_m;
  logic [1:0]       tnew_e, tnew_m;
  logic [2:0]       rs_use, rt_use;
  logic             data_stall, md_stall, stall;
  logic [CNT_W-1:0] md_cnt;

  assign op_d   = decode(Instr_D);
  assign op_e   = decode(Instr_E);
  assign op_m   = decode(Instr_M);
  assign dst_e  = dest_of(op_e, Instr_E);
  assign dst_m  = dest_of(op_m, Instr_M);
  assign tnew_e = tnew_e_of(op_e);
  assign tnew_m = (op_m == OP_LW) ? 2'd1 : 2'd0;
  assign rs_use = rs_use_of(op_d);
  assign rt_use = rt_use_of(op_d);

  assign data_stall = src_hit(rs_use, Instr_D[25:21], dst_e, tnew_e)
                   || src_hit(rt_use, Instr_D[20:16], dst_e, tnew_e)
                   || src_hit(rs_use, Instr_D[25:21], dst_m, tnew_m)
                   || src_hit(rt_use, Instr_D[20:16], dst_m, tnew_m);

  assign MD_Start  = is_md_issue(op_e);
  assign MD_Busy   = (md_cnt != '0);
  assign md_stall  = is_md_any(op_d) && (MD_Start || MD_Busy);
  assign stall     = data_stall || md_stall;

  assign En_PC     = ~stall;
  assign En_IF_ID  = ~stall;
  assign Clr_ID_EX = stall;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= '0;
    else if (MD_Start && (op_e inside {OP_MULT, OP_MULTU}))
      md_cnt <= MULT_LD;
    else if (MD_Start)
      md_cnt <= DIV_LD;
    else if (md_cnt != '0)
      md_cnt <= md_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      Stall_Cnt <= '0;
    else if (stall && (Stall_Cnt != '1))
      Stall_Cnt <= Stall_Cnt + 32'd1;
  end

endmodule
